// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and a multi-cycle
// shift-add multiplier; result and flags live in a single output slot.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_slot_free;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_load_alu;
  logic             w_load_mul;
  logic             w_mul_start;
  logic             w_mul_step;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_alu_ill;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW-1:0]     r_cnt;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_ill;
  logic             r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:  if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE: if (w_slot_free) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset pulse.
  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_in_ready  = rst_n && (r_state == S_IDLE) && w_slot_free;
    w_accept    = in_valid && w_in_ready;
    w_is_mul    = (op == OP_MUL);
    w_load_alu  = w_accept && !w_is_mul;
    w_mul_start = w_accept && w_is_mul;
    w_mul_step  = (r_state == S_MUL);
    w_load_mul  = (r_state == S_DONE) && w_slot_free;
  end

  always_comb begin
    w_sum     = {1'b0, a} + {1'b0, b};
    w_diff    = {1'b0, a} - {1'b0, b};
    w_shamt   = b[SHW-1:0];
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SLL:  w_alu_res = a << w_shamt;
      OP_SRL:  w_alu_res = a >> w_shamt;
      OP_SRA:  w_alu_res = $signed(a) >>> w_shamt;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  w_alu_res = '0;
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_mul_step) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load_alu) begin
      r_result    <= w_alu_res;
      r_carry     <= w_alu_c;
      r_ovf       <= w_alu_v;
      r_ill       <= w_alu_ill;
      r_out_valid <= 1'b1;
    end else if (w_load_mul) begin
      r_result    <= r_prod[WIDTH-1:0];
      r_carry     <= |r_prod[2*WIDTH-1:WIDTH];
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign negative  = r_result[WIDTH-1];
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: beats are predicted when accepted and
// checked in order as the sink consumes them, plus directed timing checks.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       negative;
  logic       overflow;
  logic       illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       i;
  } exp_t;

  exp_t q[$];

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
    exp_t m;
    int ux, uy, sx, sy, sh, t;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sh = uy % 8;
    m  = '0;
    case (o)
      4'd0: begin
        t = ux + uy; m.r = t[7:0]; m.c = (t > 255);
        t = sx + sy; m.v = (t > 127) || (t < -128);
      end
      4'd1: begin
        t = ux - uy; m.r = t[7:0]; m.c = (ux < uy);
        t = sx - sy; m.v = (t > 127) || (t < -128);
      end
      4'd2: m.r = x & y;
      4'd3: m.r = x | y;
      4'd4: m.r = x ^ y;
      4'd5: begin t = ux << sh; m.r = t[7:0]; end
      4'd6: begin t = ux >> sh; m.r = t[7:0]; end
      4'd7: begin t = sx >>> sh; m.r = t[7:0]; end
      4'd8: m.r = (sx < sy) ? 8'd1 : 8'd0;
      4'd9: m.r = (ux < uy) ? 8'd1 : 8'd0;
      4'd10: begin t = ux * uy; m.r = t[7:0]; m.c = (t > 255); end
      default: m.i = 1'b1;
    endcase
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("beat", {19'd0, result, zero, carry, negative, overflow, illegal},
                    {19'd0, e.r, (e.r == 8'd0), e.c, e.r[7], e.v, e.i});
      end
    end
  end

  // Entered and left at posedge+2; returns just after the accept edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top);
    int  k;
    logic acc;
    k   = 0;
    acc = 1'b0;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    while (!acc && k < 40) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(ta, tb, top));
        acc = 1'b1;
      end
      @(posedge clk); #2;
      k++;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   k;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {28'd0, carry, negative, overflow, illegal}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;

    send(8'hFF, 8'h01, 4'd0);
    @(negedge clk);
    chk("lat1_valid", 32'(out_valid), 32'd1);
    chk("add_ff_01", {23'd0, result, zero, carry, overflow}, {23'd0, 8'h00, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #2;

    send(8'h80, 8'h01, 4'd1);
    send(8'h01, 8'h02, 4'd1);
    send(8'h80, 8'h03, 4'd7);
    send(8'h80, 8'h03, 4'd6);
    send(8'hFF, 8'h01, 4'd8);
    send(8'hFF, 8'h01, 4'd9);
    send(8'h12, 8'h34, 4'hC);
    send(8'h7F, 8'h01, 4'd0);
    send(8'hA5, 8'h3C, 4'd2);
    send(8'hA5, 8'h3C, 4'd3);
    send(8'hA5, 8'h3C, 4'd4);
    send(8'h81, 8'h0F, 4'd5);
    send(8'h00, 8'h00, 4'd1);
    send(8'h05, 8'h07, 4'hF);
    repeat (3) @(posedge clk); #2;

    a = 8'd20; b = 8'd13; op = 4'd10; in_valid = 1'b1;
    @(negedge clk);
    chk("mul_accept_ready", 32'(in_ready), 32'd1);
    q.push_back(model(8'd20, 8'd13, 4'd10));
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("mul_busy_valid_%0d", i), 32'(out_valid), 32'd0);
      @(posedge clk); #2;
    end
    @(negedge clk);
    chk("mul_valid_at_9", 32'(out_valid), 32'd1);
    chk("mul_20x13", {23'd0, result, carry}, {23'd0, 8'h04, 1'b1});
    @(posedge clk); #2;

    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    end
    repeat (3) @(posedge clk); #2;

    out_ready = 1'b0;
    send(8'd3, 8'd4, 4'd0);
    a = 8'd10; b = 8'd5; op = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_held", 32'(result), 32'd7);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_ready", 32'(in_ready), 32'd1);
    q.push_back(model(8'd10, 8'd5, 4'd1));
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_result", 32'(result), 32'd5);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(posedge clk); #2;

    send(8'd200, 8'd3, 4'd10);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mul_bp_valid", 32'(out_valid), 32'd1);
    chk("mul_bp_result", {23'd0, result, carry}, {23'd0, 8'h58, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      @(negedge clk);
      chk("mul_bp_hold", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'h58});
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #2;

    send(8'd7, 8'd9, 4'd10);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mul_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_mul_ready", 32'(in_ready), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("no_beat_after_abort", 32'(seen), 32'd0);
    @(posedge clk); #2;
    send(8'd2, 8'd3, 4'd0);
    @(negedge clk);
    chk("post_abort_add", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'd5});
    repeat (3) @(posedge clk); #2;

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Next-generation parametrised ALU for the datapath examples.
- Results and flags are registered, with valid/ready handshakes on input and output.
- Adds arithmetic shift, signed and unsigned compare, and a multi-cycle shift-add multiplier.
- Full flag set: zero, carry, negative, overflow, illegal-op.
- Sits between an operand source (decoder/sequencer) and a result sink that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0]. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active low
- in_valid  input  1  operand/op beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  4  operation code
- out_valid  output  1  result beat valid
- out_ready  input  1  sink accepts the result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  carry/borrow/unsigned-overflow
- negative  output  1  result[WIDTH-1]
- overflow  output  1  signed overflow (ADD/SUB only)
- illegal  output  1  op code not defined

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=0 while low, out_valid=0, result=0, all flags=0, multiplier regs cleared. Reset mid-MUL aborts the operation; no output beat is produced.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift ops use b[SHW-1:0]
  - 8 SLT (signed a<b -> 1 else 0), 9 SLTU (unsigned)
  - 10 MUL (low WIDTH bits of a*b, unsigned)
  - 11..15 illegal
- Flags:
  - ADD: carry = carry-out of bit WIDTH-1.
  - SUB: carry = borrow, i.e. unsigned a<b.
  - ADD/SUB: overflow = signed overflow of the WIDTH-bit result.
  - MUL: carry = 1 when any bit of the 2*WIDTH product above WIDTH-1 is set.
  - All other ops: carry=0, overflow=0.
  - zero and negative are always derived from the registered result.
  - Illegal op: result=0, zero=1, illegal=1, other flags 0, still emits one beat.
- Output slot: a single register. Result and flags are held stable while out_valid=1 and out_ready=0. The slot frees on the cycle out_valid&&out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A beat is accepted on in_valid&&in_ready.
- FSM:
  - IDLE: accept a non-MUL op -> load output slot at that edge (out_valid next cycle, latency 1). Back-to-back non-MUL ops sustain 1 beat/cycle with out_ready=1. Accept MUL -> MUL; latch a, b; clear accumulator; count=0.
  - MUL: one shift-add step per cycle. After WIDTH steps (count==WIDTH-1) -> DONE.
  - DONE: if output slot free (!out_valid || out_ready) load result/flags, -> IDLE; else remain in DONE.
  - Unblocked MUL: out_valid asserts WIDTH+1 cycles after the accept edge.
- in_ready=0 throughout MUL and DONE; in_valid is ignored there, and the source must hold its beat.
- Acceptance and consumption in the same cycle are legal: the slot is overwritten with the new result and out_valid stays 1.
- a/b/op are sampled only at accept; changes at other times have no effect.

Test Plan:
- WIDTH=8, ADD a=8'hFF b=8'h01, out_ready=1 -> next cycle result=8'h00, zero=1, carry=1, overflow=0, negative=0.
- SUB a=8'h80 b=8'h01 -> result=8'h7F, overflow=1, carry=0, negative=0. SUB a=8'h01 b=8'h02 -> result=8'hFF, carry=1, negative=1.
- SRA a=8'h80 b=8'h03 -> 8'hF0. SRL same operands -> 8'h10. SLT a=8'hFF b=8'h01 -> 1. SLTU same operands -> 0. op=4'hC -> result=0, illegal=1, zero=1.
- MUL a=20 b=13 -> out_valid exactly 9 cycles after accept; result=8'h04, carry=1. in_ready=0 for cycles 1..8 after accept.
- Backpressure: out_ready=0, issue ADD 3+4, then hold a second beat -> result=7 held stable, in_ready=0. Raise out_ready for one cycle -> 7 consumed, second beat accepted same cycle, its result appears next cycle. MUL finishing while the slot is full stays in DONE until out_ready.
- Pull rst_n low 4 cycles into a MUL -> out_valid=0 immediately, no beat after release. in_ready=1 on the first clock after deassert; the next ADD works normally.
